// File: rtl/mem_write_monitor_pkg.sv
// mem_write_monitor_pkg
// Shared types for the data-memory write monitor: FSM state and failure code
// encodings, plus a width helper that never returns zero.
// Optional feature macro used by the monitor: MEM_WRITE_MONITOR_IGNORE_EN.
package mem_write_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } wmon_state_t;

    typedef enum logic [1:0] {
        FC_NONE     = 2'd0,
        FC_MISMATCH = 2'd1,
        FC_TIMEOUT  = 2'd2,
        FC_CONFIG   = 2'd3
    } wmon_fail_t;

    // Bit width needed to index n items, at least 1 so vectors stay legal.
    function automatic int unsigned wmon_clog2(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_write_monitor_if.sv
// mem_write_monitor_if
// Bundles the store port, expected-table programming port, run control and
// status outputs of mem_write_monitor.
//   slave  : monitor side (stores/table/arm in, status out)
//   master : driver side (core / bench)
// The ign_en/ign_base/ign_mask window exists only with MEM_WRITE_MONITOR_IGNORE_EN.
interface mem_write_monitor_if #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NUM_EXP = 8
) ();
    import mem_write_monitor_pkg::*;

    localparam int unsigned IW = wmon_clog2(NUM_EXP);
    localparam int unsigned CW = wmon_clog2(NUM_EXP + 1);

    logic             memwrite;
    logic [WIDTH-1:0] dataadr;
    logic [WIDTH-1:0] writedata;
    logic             exp_we;
    logic [IW-1:0]    exp_idx;
    logic [WIDTH-1:0] exp_addr;
    logic [WIDTH-1:0] exp_data;
    logic [CW-1:0]    exp_len;
    logic             arm;
`ifdef MEM_WRITE_MONITOR_IGNORE_EN
    logic             ign_en;
    logic [WIDTH-1:0] ign_base;
    logic [WIDTH-1:0] ign_mask;
`endif
    logic [1:0]       state;
    logic             done;
    logic             pass;
    logic [1:0]       fail_code;
    logic [CW-1:0]    match_count;
    logic [WIDTH-1:0] fail_addr;
    logic [WIDTH-1:0] fail_data;

`ifdef MEM_WRITE_MONITOR_IGNORE_EN
    modport slave (
        input  memwrite, dataadr, writedata, exp_we, exp_idx, exp_addr, exp_data,
               exp_len, arm, ign_en, ign_base, ign_mask,
        output state, done, pass, fail_code, match_count, fail_addr, fail_data
    );
    modport master (
        output memwrite, dataadr, writedata, exp_we, exp_idx, exp_addr, exp_data,
               exp_len, arm, ign_en, ign_base, ign_mask,
        input  state, done, pass, fail_code, match_count, fail_addr, fail_data
    );
`else
    modport slave (
        input  memwrite, dataadr, writedata, exp_we, exp_idx, exp_addr, exp_data,
               exp_len, arm,
        output state, done, pass, fail_code, match_count, fail_addr, fail_data
    );
    modport master (
        output memwrite, dataadr, writedata, exp_we, exp_idx, exp_addr, exp_data,
               exp_len, arm,
        input  state, done, pass, fail_code, match_count, fail_addr, fail_data
    );
`endif

endinterface

// File: rtl/mem_write_monitor_table.sv
// mem_write_monitor_table
// Expected address/data table: NUM_EXP entries, one write port, one
// combinational read port, no reset (contents survive monitor reset).
//   i_we/i_wr_idx/i_wr_addr/i_wr_data : write port (out-of-range index dropped)
//   i_rd_idx -> o_rd_addr/o_rd_data   : asynchronous read
module mem_write_monitor_table
    import mem_write_monitor_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NUM_EXP = 8
) (
    input  logic                         clk,
    input  logic                         i_we,
    input  logic [wmon_clog2(NUM_EXP)-1:0] i_wr_idx,
    input  logic [WIDTH-1:0]             i_wr_addr,
    input  logic [WIDTH-1:0]             i_wr_data,
    input  logic [wmon_clog2(NUM_EXP)-1:0] i_rd_idx,
    output logic [WIDTH-1:0]             o_rd_addr,
    output logic [WIDTH-1:0]             o_rd_data
);

    logic [WIDTH-1:0] r_addr [NUM_EXP];
    logic [WIDTH-1:0] r_data [NUM_EXP];

    // Write port
    always_ff @(posedge clk) begin
        if (i_we && (32'(i_wr_idx) < NUM_EXP)) begin
            r_addr[i_wr_idx] <= i_wr_addr;
            r_data[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_addr = r_addr[i_rd_idx];
    assign o_rd_data = r_data[i_rd_idx];

endmodule

// File: rtl/mem_write_monitor.sv
// mem_write_monitor
// Checks the core's store stream in order against a programmed table of
// expected address/data pairs and reports PASS, or FAIL with a reason code.
//   clk, reset : clock and synchronous active-high reset
//   mon        : mem_write_monitor_if.slave (stores, table port, arm, status)
// Define MEM_WRITE_MONITOR_IGNORE_EN to add the ign_* scratch-store window.
module mem_write_monitor
    import mem_write_monitor_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NUM_EXP = 8,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    mem_write_monitor_if.slave mon
);

    localparam int unsigned IW = wmon_clog2(NUM_EXP);
    localparam int unsigned CW = wmon_clog2(NUM_EXP + 1);
    localparam int unsigned TW = wmon_clog2(TIMEOUT);

    wmon_state_t      r_state, w_state_nxt;
    wmon_fail_t       r_fail_code, w_fail_nxt;
    logic [CW-1:0]    r_match_count, w_cnt_nxt;
    logic [CW-1:0]    r_len, w_len_nxt;
    logic [TW-1:0]    r_tcnt, w_tcnt_nxt;
    logic [WIDTH-1:0] r_fail_addr, w_faddr_nxt;
    logic [WIDTH-1:0] r_fail_data, w_fdata_nxt;
    logic             r_done, r_pass;

    logic [WIDTH-1:0] w_exp_addr, w_exp_data;
    logic             w_ignore, w_store, w_match, w_tmo, w_len_bad;
    logic [CW-1:0]    w_cnt_inc;

    // Table is frozen while a run is in progress
    mem_write_monitor_table #(
        .WIDTH   (WIDTH),
        .NUM_EXP (NUM_EXP)
    ) u_table (
        .clk       (clk),
        .i_we      (mon.exp_we && (r_state != ST_RUN)),
        .i_wr_idx  (mon.exp_idx),
        .i_wr_addr (mon.exp_addr),
        .i_wr_data (mon.exp_data),
        .i_rd_idx  (IW'(r_match_count)),
        .o_rd_addr (w_exp_addr),
        .o_rd_data (w_exp_data)
    );

`ifdef MEM_WRITE_MONITOR_IGNORE_EN
    assign w_ignore = mon.ign_en &&
                      ((mon.dataadr & mon.ign_mask) == (mon.ign_base & mon.ign_mask));
`else
    assign w_ignore = 1'b0;
`endif

    // An X/Z compare result falls into the mismatch branch below
    assign w_store   = mon.memwrite && !w_ignore;
    assign w_match   = (mon.dataadr == w_exp_addr) && (mon.writedata == w_exp_data);
    assign w_tmo     = (r_tcnt == TW'(TIMEOUT - 1));
    assign w_cnt_inc = r_match_count + CW'(1);
    assign w_len_bad = (mon.exp_len == '0) || (32'(mon.exp_len) > NUM_EXP);

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt = r_state;
        w_fail_nxt  = r_fail_code;
        w_cnt_nxt   = r_match_count;
        w_len_nxt   = r_len;
        w_tcnt_nxt  = r_tcnt;
        w_faddr_nxt = r_fail_addr;
        w_fdata_nxt = r_fail_data;
        case (r_state)
            ST_RUN: begin
                if (w_store) begin
                    if (w_match) begin
                        w_cnt_nxt = w_cnt_inc;
                        // A final match beats a timeout on the same edge
                        if (w_cnt_inc == r_len) begin
                            w_state_nxt = ST_PASS;
                        end else if (w_tmo) begin
                            w_state_nxt = ST_FAIL;
                            w_fail_nxt  = FC_TIMEOUT;
                        end else begin
                            w_tcnt_nxt = r_tcnt + TW'(1);
                        end
                    end else begin
                        w_state_nxt = ST_FAIL;
                        w_fail_nxt  = FC_MISMATCH;
                        w_faddr_nxt = mon.dataadr;
                        w_fdata_nxt = mon.writedata;
                    end
                end else if (w_tmo) begin
                    w_state_nxt = ST_FAIL;
                    w_fail_nxt  = FC_TIMEOUT;
                end else begin
                    w_tcnt_nxt = r_tcnt + TW'(1);
                end
            end
            default: begin
                if (mon.arm) begin
                    w_cnt_nxt   = '0;
                    w_tcnt_nxt  = '0;
                    w_faddr_nxt = '0;
                    w_fdata_nxt = '0;
                    if (w_len_bad) begin
                        w_state_nxt = ST_FAIL;
                        w_fail_nxt  = FC_CONFIG;
                    end else begin
                        w_state_nxt = ST_RUN;
                        w_fail_nxt  = FC_NONE;
                        w_len_nxt   = mon.exp_len;
                    end
                end
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_fail_code   <= FC_NONE;
            r_match_count <= '0;
            r_len         <= '0;
            r_tcnt        <= '0;
            r_fail_addr   <= '0;
            r_fail_data   <= '0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_fail_code   <= w_fail_nxt;
            r_match_count <= w_cnt_nxt;
            r_len         <= w_len_nxt;
            r_tcnt        <= w_tcnt_nxt;
            r_fail_addr   <= w_faddr_nxt;
            r_fail_data   <= w_fdata_nxt;
            r_done        <= (w_state_nxt == ST_PASS) || (w_state_nxt == ST_FAIL);
            r_pass        <= (w_state_nxt == ST_PASS);
        end
    end

    assign mon.state       = r_state;
    assign mon.done        = r_done;
    assign mon.pass        = r_pass;
    assign mon.fail_code   = r_fail_code;
    assign mon.match_count = r_match_count;
    assign mon.fail_addr   = r_fail_addr;
    assign mon.fail_data   = r_fail_data;

endmodule

// File: tb/tb_mem_write_monitor.sv
// tb_mem_write_monitor
// Directed bench for mem_write_monitor: two instances (TIMEOUT=16 and
// TIMEOUT=4) share clock and reset; expected status is queued when stimulus
// is applied and compared once the DUT has registered the result.
module tb_mem_write_monitor;
    import mem_write_monitor_pkg::*;

    localparam int unsigned W = 32;
    localparam int unsigned N = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_write_monitor_if #(.WIDTH(W), .NUM_EXP(N)) b16 ();
    mem_write_monitor_if #(.WIDTH(W), .NUM_EXP(N)) b4 ();

    mem_write_monitor #(.WIDTH(W), .NUM_EXP(N), .TIMEOUT(16)) u_dut16 (
        .clk   (clk),
        .reset (reset),
        .mon   (b16)
    );

    mem_write_monitor #(.WIDTH(W), .NUM_EXP(N), .TIMEOUT(4)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .mon   (b4)
    );

    typedef struct {
        string       tag;
        logic [1:0]  st;
        logic [1:0]  fc;
        logic [3:0]  mc;
        logic [31:0] fa;
        logic [31:0] fd;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string tag, input string fld,
                       input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s.%s: got %0h expected %0h", tag, fld, got, exp);
        end
    endtask

    task automatic push(input string tag, input int st, input int fc, input int mc,
                        input int fa, input int fd);
        exp_t e;
        e.tag = tag;
        e.st  = 2'(st);
        e.fc  = 2'(fc);
        e.mc  = 4'(mc);
        e.fa  = 32'(fa);
        e.fd  = 32'(fd);
        sb_q.push_back(e);
    endtask

    task automatic pop_cmp(input logic [1:0] st, input logic [1:0] fc, input logic [3:0] mc,
                           input logic [31:0] fa, input logic [31:0] fd,
                           input logic dn, input logic ps);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_chk++;
            n_err++;
            $error("FAIL scoreboard: queue empty, got state %0d expected an entry", st);
            return;
        end
        e = sb_q.pop_front();
        cmp(e.tag, "state",       32'(st), 32'(e.st));
        cmp(e.tag, "fail_code",   32'(fc), 32'(e.fc));
        cmp(e.tag, "match_count", 32'(mc), 32'(e.mc));
        cmp(e.tag, "fail_addr",   fa,      e.fa);
        cmp(e.tag, "fail_data",   fd,      e.fd);
        cmp(e.tag, "done",        32'(dn), 32'(e.st >= 2'd2));
        cmp(e.tag, "pass",        32'(ps), 32'(e.st == 2'd2));
    endtask

    task automatic chk16();
        pop_cmp(b16.state, b16.fail_code, b16.match_count, b16.fail_addr,
                b16.fail_data, b16.done, b16.pass);
    endtask

    task automatic chk4();
        pop_cmp(b4.state, b4.fail_code, b4.match_count, b4.fail_addr,
                b4.fail_data, b4.done, b4.pass);
    endtask

    task automatic wr16(input int idx, input int a, input int d);
        b16.exp_we   = 1'b1;
        b16.exp_idx  = 3'(idx);
        b16.exp_addr = 32'(a);
        b16.exp_data = 32'(d);
        tick();
        b16.exp_we   = 1'b0;
    endtask

    task automatic arm16(input int len);
        b16.arm     = 1'b1;
        b16.exp_len = 4'(len);
        tick();
        b16.arm     = 1'b0;
    endtask

    task automatic st16(input int a, input int d);
        b16.memwrite  = 1'b1;
        b16.dataadr   = 32'(a);
        b16.writedata = 32'(d);
        tick();
        b16.memwrite  = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        b16.memwrite = 1'b0; b16.dataadr = '0; b16.writedata = '0;
        b16.exp_we = 1'b0; b16.exp_idx = '0; b16.exp_addr = '0; b16.exp_data = '0;
        b16.exp_len = '0; b16.arm = 1'b0;
        b4.memwrite = 1'b0; b4.dataadr = '0; b4.writedata = '0;
        b4.exp_we = 1'b0; b4.exp_idx = '0; b4.exp_addr = '0; b4.exp_data = '0;
        b4.exp_len = '0; b4.arm = 1'b0;
`ifdef MEM_WRITE_MONITOR_IGNORE_EN
        b16.ign_en = 1'b0; b16.ign_base = '0; b16.ign_mask = '0;
        b4.ign_en = 1'b0; b4.ign_base = '0; b4.ign_mask = '0;
`endif
        tick();
        tick();
        push("reset", 0, 0, 0, 0, 0); chk16();
        reset = 1'b0;

        // Single-entry pass, with a scratch store skipped when the window exists
        wr16(0, 84, 224);
`ifdef MEM_WRITE_MONITOR_IGNORE_EN
        b16.ign_en = 1'b1; b16.ign_base = 32'd80; b16.ign_mask = 32'hFFFF_FFFF;
`endif
        arm16(1);
        push("t1_arm", 1, 0, 0, 0, 0); chk16();
`ifdef MEM_WRITE_MONITOR_IGNORE_EN
        st16(80, 7);
        push("t1_ignored", 1, 0, 0, 0, 0); chk16();
`endif
        st16(84, 224);
        push("t1_pass", 2, 0, 1, 0, 0); chk16();
        st16(84, 223);
        push("t1_sticky", 2, 0, 1, 0, 0); chk16();

        // Data mismatch
        arm16(1);
        push("t2_arm", 1, 0, 0, 0, 0); chk16();
        st16(84, 223);
        push("t2_mismatch", 3, 1, 0, 84, 223); chk16();

        // Timeout: still RUN after 15 cycles, FAIL after 16
        arm16(1);
        repeat (15) tick();
        push("t3_cycle15", 1, 0, 0, 0, 0); chk16();
        tick();
        push("t3_timeout", 3, 2, 0, 0, 0); chk16();

        // Reset mid-run, then table retention
        wr16(0, 0, 1);
        wr16(1, 4, 2);
        wr16(2, 8, 3);
        arm16(3);
        st16(0, 1);
        push("t4_m1", 1, 0, 1, 0, 0); chk16();
        st16(4, 2);
        push("t4_m2", 1, 0, 2, 0, 0); chk16();
        reset = 1'b1;
        tick();
        push("t4_reset", 0, 0, 0, 0, 0); chk16();
        reset = 1'b0;
        arm16(3);
        st16(0, 1);
        st16(4, 2);
        st16(8, 3);
        push("t4_retained", 2, 0, 3, 0, 0); chk16();

        // Table write during RUN is dropped
        arm16(1);
        wr16(0, 0, 32'hFF);
        push("t6_we_run", 1, 0, 0, 0, 0); chk16();
        st16(0, 1);
        push("t6_pass", 2, 0, 1, 0, 0); chk16();

        // Table write and arm on the same edge: run sees the new entry
        b16.exp_we = 1'b1; b16.exp_idx = 3'd0; b16.exp_addr = 32'd12; b16.exp_data = 32'd5;
        b16.arm = 1'b1; b16.exp_len = 4'd1;
        tick();
        b16.exp_we = 1'b0; b16.arm = 1'b0;
        push("we_arm_run", 1, 0, 0, 0, 0); chk16();
        st16(12, 5);
        push("we_arm_pass", 2, 0, 1, 0, 0); chk16();

        // Arm while running is ignored
        arm16(2);
        st16(12, 5);
        arm16(1);
        push("arm_in_run", 1, 0, 1, 0, 0); chk16();
        st16(4, 2);
        push("arm_in_run_pass", 2, 0, 2, 0, 0); chk16();

        // Bad lengths
        arm16(0);
        push("cfg_len0", 3, 3, 0, 0, 0); chk16();
        arm16(9);
        push("cfg_len9", 3, 3, 0, 0, 0); chk16();

        // Reset wins over arm
        reset = 1'b1; b16.arm = 1'b1; b16.exp_len = 4'd1;
        tick();
        reset = 1'b0; b16.arm = 1'b0;
        push("reset_arm", 0, 0, 0, 0, 0); chk16();

        // TIMEOUT=4: matching store on the final RUN cycle passes
        b4.exp_we = 1'b1; b4.exp_idx = 3'd0; b4.exp_addr = 32'd20; b4.exp_data = 32'd30;
        tick();
        b4.exp_we = 1'b0;
        b4.arm = 1'b1; b4.exp_len = 4'd1;
        tick();
        b4.arm = 1'b0;
        repeat (3) tick();
        push("t5_run", 1, 0, 0, 0, 0); chk4();
        b4.memwrite = 1'b1; b4.dataadr = 32'd20; b4.writedata = 32'd30;
        tick();
        b4.memwrite = 1'b0;
        push("t5_pass", 2, 0, 1, 0, 0); chk4();
        b4.arm = 1'b1;
        tick();
        b4.arm = 1'b0;
        repeat (3) tick();
        push("t5_run2", 1, 0, 0, 0, 0); chk4();
        tick();
        push("t5_timeout", 3, 2, 0, 0, 0); chk4();

        n_chk++;
        assert (sb_q.size() == 0) else begin
            n_err++;
            $error("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/mem_write_monitor.md
# mem_write_monitor

Synthesizable, parametrised self-checking monitor for the data-memory write port of the MIPS cores. It captures every store (`memwrite`, `dataadr`, `writedata`) and compares the stores in order against a programmable table of expected address/data pairs. Scratch writes that fall in an ignore window are skipped. The block reports pass, mismatch, timeout or configuration error. It sits beside `top` in simulation and FPGA bring-up, and replaces ad-hoc single-pair checks in benches.

## Interface
- `WIDTH`, 32: address/data width.
- `NUM_EXP`, 8: expected-table depth.
- `TIMEOUT`, 1024: maximum cycles in RUN before failure.
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `memwrite`  in  1  store strobe from the core.
- `dataadr`  in  WIDTH  store address.
- `writedata`  in  WIDTH  store data.
- `exp_we`  in  1  table write strobe.
- `exp_idx`  in  $clog2(NUM_EXP)  table index.
- `exp_addr`, `exp_data`  in  WIDTH  expected pair.
- `exp_len`  in  $clog2(NUM_EXP+1)  entries to check; sampled on arm.
- `arm`  in  1  start a check run.
- `ign_en`, `ign_base`, `ign_mask`  in  1/WIDTH/WIDTH  ignore window. Present only with the ignore macro.
- `state`  out  2  IDLE=0, RUN=1, PASS=2, FAIL=3.
- `done`  out  1  state is PASS or FAIL.
- `pass`  out  1  state is PASS.
- `fail_code`  out  2  0 none, 1 mismatch, 2 timeout, 3 config.
- `match_count`  out  $clog2(NUM_EXP+1)  matched entries.
- `fail_addr`, `fail_data`  out  WIDTH  offending store; zero otherwise.

## Operation
- Reset: state IDLE; done, pass, fail_code, match_count, fail_addr, fail_data and the timeout counter all become 0. Table contents are retained.
- Table write (`exp_we`) is accepted only in IDLE, PASS or FAIL. It is ignored in RUN. An out-of-range `exp_idx` is ignored.
- `arm` in any state other than RUN behaves as follows:
  - If `exp_len` is 0 or greater than NUM_EXP, go to FAIL with code 3.
  - Otherwise latch `exp_len`, clear the counters and outputs, and go to RUN.
- `arm` in RUN is ignored.
- In RUN, each cycle with `memwrite`=1 is evaluated in this order:
  - Ignore: the store is dropped if `ign_en` and (`dataadr` & `ign_mask`) == (`ign_base` & `ign_mask`).
  - Compare: the store is compared against entry `match_count`.
  - Match: `match_count`++. When `match_count` reaches the latched length, go to PASS.
  - Mismatch: go to FAIL with code 1, and capture `dataadr` and `writedata`.
- The timeout counter increments every RUN cycle. When it reaches TIMEOUT-1 with no terminating store, go to FAIL with code 2.
- PASS and FAIL are sticky until `arm` or `reset`. Stores in these states are ignored.
- Comparison is full-width equality. X or Z on a compared bit counts as a mismatch in simulation; use `!==` semantics in the checker model.

## Timing
- Store sampled at edge N, result visible after edge N: `state`, `done`, `pass` and `fail_code` are valid from cycle N+1. This gives 1-cycle latency.
- `arm` at edge N: RUN from cycle N+1. The first store that can be checked is at edge N+1.
- Timeout: FAIL appears exactly TIMEOUT cycles after entering RUN.
- A final-matching store and the timeout expiring on the same edge resolve to PASS. A store takes priority over the timeout.
- `reset` and `arm` on the same edge resolve to IDLE. Reset wins.
- `exp_we` and `arm` on the same edge: the write lands first, and the run uses the updated table.
- Table read is combinational on `match_count`. No extra latency.

## Configuration
- `MEM_WRITE_MONITOR_IGNORE_EN` defined: the `ign_*` ports and the ignore check exist.
- Undefined: the ports are absent and every store in RUN is compared.

## Structure
- `mem_write_monitor_pkg` contains:
  - `wmon_state_t` enum (IDLE, RUN, PASS, FAIL);
  - `wmon_fail_t` enum (NONE, MISMATCH, TIMEOUT, CONFIG);
  - the state and code encodings.
- Sub-module `mem_write_monitor_table`: NUM_EXP×2×WIDTH register file with one write port and one combinational read port, no reset.
- The top level holds the FSM, counters and capture registers.

## Test plan
- Program entry 0 = (84, 224), `exp_len`=1, ignore window base 80 / mask 0xFFFFFFFF. Arm, then store (80,7) followed by (84,224). Required: PASS one cycle after the second store, `match_count`=1.
- Same table, store (84,223). Required: FAIL, `fail_code`=1, `fail_addr`=84, `fail_data`=223, `match_count`=0.
- TIMEOUT=16, arm, then no stores. Required: FAIL with `fail_code`=2 on cycle 16 after RUN entry, and not on cycle 15.
- Three entries (0,1), (4,2), (8,3). Hold `reset` after the second match. Required: IDLE with all outputs 0. Re-arm and store all three entries. Required: PASS, proving the table was retained.
- TIMEOUT=4, `exp_len`=1. Matching store on the final RUN cycle. Required: PASS, not timeout.
- `exp_we` during RUN overwrites entry 0 with (0,0xFF); then store the originally programmed pair. Required: PASS, showing the write was ignored. Also `arm` with `exp_len`=0. Required: FAIL with `fail_code`=3.
